// File: rtl/scc_wave_channel_mixer.sv
// SCC wave channel mixer: fetches per-channel wave samples and mixes volume-scaled channels A-E.
// Latency: sample valid 2 cycles after wave_update; one mix per 6-slot frame, presented in slot 5.
// Backpressure: none, free-running TDM; mix_valid pulses once per frame. Optional macro: SCC_SHARED_WAVE_DE_EN.
module scc_wave_channel_mixer #(
  parameter int VOLUME_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               active,
  input  logic [4:0]               wave_address,
  input  logic                     wave_update,
  output logic [7:0]               ram_address,
  output logic                     ram_read,
  input  logic [7:0]               ram_rdata,
  input  logic [VOLUME_WIDTH-1:0]  reg_volume_a,
  input  logic [VOLUME_WIDTH-1:0]  reg_volume_b,
  input  logic [VOLUME_WIDTH-1:0]  reg_volume_c,
  input  logic [VOLUME_WIDTH-1:0]  reg_volume_d,
  input  logic [VOLUME_WIDTH-1:0]  reg_volume_e,
  input  logic [4:0]               reg_enable,
  output logic [VOLUME_WIDTH+10:0] mix_out,
  output logic                     mix_valid
);

  localparam int PW = 8 + VOLUME_WIDTH;
  localparam int MW = PW + 3;

  logic [7:0]           ram_address_q, ram_address_d;
  logic                 ram_read_q, ram_read_d;
  logic [2:0]           pend_q, pend_d;
  logic [7:0]           sample_q [5];
  logic signed [MW-1:0] acc_q, acc_d;
  logic signed [MW-1:0] mix_out_q, mix_out_d;
  logic                 mix_valid_q, mix_valid_d;

  logic [2:0]             bank;
  logic [7:0]             cur_sample;
  logic [VOLUME_WIDTH-1:0] cur_vol;
  logic                   cur_en;
  logic signed [PW-1:0]   sample_ext;
  logic signed [PW-1:0]   vol_ext;
  logic signed [PW-1:0]   product;
  logic signed [MW-1:0]   product_ext;

  // Wave RAM bank for the channel in the current slot.
  always_comb begin
    bank = active;
`ifdef SCC_SHARED_WAVE_DE_EN
    // Original SCC: channel E shares channel D's waveform.
    if (active == 3'd4) bank = 3'd3;
`endif
  end

  // Fetch request: only channel slots issue reads; address holds otherwise.
  always_comb begin
    ram_read_d    = 1'b0;
    ram_address_d = ram_address_q;
    pend_d        = pend_q;
    if (wave_update && (active < 3'd5)) begin
      ram_read_d    = 1'b1;
      ram_address_d = {bank, wave_address + 5'd1};
      pend_d        = active;
    end
  end

  // Select the sample/volume/enable of the channel owning the current slot.
  always_comb begin
    cur_sample = 8'd0;
    cur_vol    = '0;
    cur_en     = 1'b0;
    case (active)
      3'd0: begin cur_sample = sample_q[0]; cur_vol = reg_volume_a; cur_en = reg_enable[0]; end
      3'd1: begin cur_sample = sample_q[1]; cur_vol = reg_volume_b; cur_en = reg_enable[1]; end
      3'd2: begin cur_sample = sample_q[2]; cur_vol = reg_volume_c; cur_en = reg_enable[2]; end
      3'd3: begin cur_sample = sample_q[3]; cur_vol = reg_volume_d; cur_en = reg_enable[3]; end
      3'd4: begin cur_sample = sample_q[4]; cur_vol = reg_volume_e; cur_en = reg_enable[4]; end
      default: ;
    endcase
  end

  // Signed sample times unsigned volume; operands widened to PW so the product cannot overflow.
  always_comb begin
    sample_ext  = {{VOLUME_WIDTH{cur_sample[7]}}, cur_sample};
    vol_ext     = {8'd0, cur_vol};
    product     = cur_en ? (sample_ext * vol_ext) : '0;
    product_ext = {{3{product[PW-1]}}, product};
  end

  // Accumulate across slots 0..4; the final sum is registered at the end of slot 4 so
  // mix_out/mix_valid are presented during slot 5.
  always_comb begin
    acc_d       = acc_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    case (active)
      3'd0: acc_d = product_ext;
      3'd1, 3'd2, 3'd3: acc_d = acc_q + product_ext;
      3'd4: begin
        acc_d       = acc_q + product_ext;
        mix_out_d   = acc_d;
        mix_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State registers; a returning read lands in the channel recorded at request time.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_address_q <= 8'd0;
      ram_read_q    <= 1'b0;
      pend_q        <= 3'd0;
      acc_q         <= '0;
      mix_out_q     <= '0;
      mix_valid_q   <= 1'b0;
      for (int i = 0; i < 5; i++) sample_q[i] <= 8'd0;
    end else begin
      ram_address_q <= ram_address_d;
      ram_read_q    <= ram_read_d;
      pend_q        <= pend_d;
      acc_q         <= acc_d;
      mix_out_q     <= mix_out_d;
      mix_valid_q   <= mix_valid_d;
      if (ram_read_q) begin
        case (pend_q)
          3'd0: sample_q[0] <= ram_rdata;
          3'd1: sample_q[1] <= ram_rdata;
          3'd2: sample_q[2] <= ram_rdata;
          3'd3: sample_q[3] <= ram_rdata;
          3'd4: sample_q[4] <= ram_rdata;
          default: ;
        endcase
      end
    end
  end

  assign ram_address = ram_address_q;
  assign ram_read    = ram_read_q;
  assign mix_out     = mix_out_q;
  assign mix_valid   = mix_valid_q;

endmodule

// File: tb/tb_scc_wave_channel_mixer.sv
// Bench for scc_wave_channel_mixer: directed slot sequences, expected mixes queued and
// checked by a monitor whenever mix_valid is seen; RAM address/strobe checked inline.
module tb_scc_wave_channel_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  active;
  logic [4:0]  wave_address;
  logic        wave_update;
  logic [7:0]  ram_address;
  logic        ram_read;
  logic [7:0]  ram_rdata;
  logic [3:0]  vol_a, vol_b, vol_c, vol_d, vol_e;
  logic [4:0]  reg_enable;
  logic [14:0] mix_out;
  logic        mix_valid;

  logic [7:0]  mem [256];
  logic [14:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rd_count = 0;

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_address];

  scc_wave_channel_mixer #(.VOLUME_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .active       (active),
    .wave_address (wave_address),
    .wave_update  (wave_update),
    .ram_address  (ram_address),
    .ram_read     (ram_read),
    .ram_rdata    (ram_rdata),
    .reg_volume_a (vol_a),
    .reg_volume_b (vol_b),
    .reg_volume_c (vol_c),
    .reg_volume_d (vol_d),
    .reg_volume_e (vol_e),
    .reg_enable   (reg_enable),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid)
  );

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d) required 0x%0h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  task automatic push(input int v);
    exp_q.push_back(15'(v));
  endtask

  task automatic fill_mem(input logic use_addr, input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = use_addr ? 8'(i) : v;
  endtask

  task automatic slot(input logic [2:0] a, input logic upd, input logic [4:0] wa);
    active       = a;
    wave_update  = upd;
    wave_address = wa;
    @(posedge clk);
    #1;
    wave_update  = 1'b0;
  endtask

  // One full frame; channel k updates when upd_mask[k] is set, using wave_address=k.
  task automatic frame(input logic [4:0] upd_mask);
    for (int k = 0; k < 6; k++) slot(3'(k), (k < 5) ? upd_mask[k] : 1'b0, 5'(k));
  endtask

  task automatic set_vols(input logic [3:0] a, b, c, d, e);
    vol_a = a; vol_b = b; vol_c = c; vol_d = d; vol_e = e;
  endtask

  task automatic monitor();
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (ram_read) rd_count++;
      if (mix_valid && !reset) begin
        check("mix_valid_slot", {12'd0, active}, 15'd5);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mix_unexpected: got 0x%0h with no expected value queued", mix_out);
        end else begin
          e = exp_q.pop_front();
          check("mix_out", mix_out, e);
        end
      end
    end
  endtask

  task automatic stimulus();
    int rd0;
    // Reset state
    reset = 1'b1; active = 3'd0; wave_address = 5'd0; wave_update = 1'b0;
    set_vols(4'd15, 4'd15, 4'd15, 4'd15, 4'd15);
    reg_enable = 5'b11111;
    fill_mem(1'b1, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_address", {7'd0, ram_address}, 15'd0);
    check("rst_ram_read", {14'd0, ram_read}, 15'd0);
    check("rst_mix_out", mix_out, 15'd0);
    check("rst_mix_valid", {14'd0, mix_valid}, 15'd0);
    reset = 1'b0;

    // Three idle frames: zero mix, no RAM reads
    rd0 = rd_count;
    repeat (3) begin push(0); frame(5'b00000); end
    check("idle_no_ram_read", 15'(rd_count - rd0), 15'd0);

    // Slot 2, wave_address 7 -> address 0x48; C becomes 0x48 (72)
    push(0);
    slot(3'd0, 1'b0, 5'd0);
    slot(3'd1, 1'b0, 5'd0);
    slot(3'd2, 1'b1, 5'd7);
    check("fetch_c_addr", {7'd0, ram_address}, 15'h48);
    check("fetch_c_read", {14'd0, ram_read}, 15'd1);
    slot(3'd3, 1'b0, 5'd0);
    check("fetch_c_read_drop", {14'd0, ram_read}, 15'd0);
    slot(3'd4, 1'b0, 5'd0);
    slot(3'd5, 1'b0, 5'd0);

    // Slot 1, wave_address 31 -> index wraps: address 0x20; B becomes 32
    push(72 * 15);
    slot(3'd0, 1'b0, 5'd0);
    slot(3'd1, 1'b1, 5'd31);
    check("wrap_b_addr", {7'd0, ram_address}, 15'h20);
    check("wrap_b_read", {14'd0, ram_read}, 15'd1);
    for (int k = 2; k < 6; k++) slot(3'(k), 1'b0, 5'd0);

    // All channels load -128 back to back; this frame still mixes B=32, C=72
    fill_mem(1'b0, 8'h80);
    push((32 + 72) * 15);
    frame(5'b11111);
    push(-9600);
    frame(5'b00000);

    // Disable C: mix drops by C's product; C still reloads (mem[0x4A] = 74)
    fill_mem(1'b1, 8'd0);
    reg_enable = 5'b11011;
    push(-128 * 15 * 4);
    slot(3'd0, 1'b0, 5'd0);
    slot(3'd1, 1'b0, 5'd0);
    slot(3'd2, 1'b1, 5'd9);
    check("disabled_c_addr", {7'd0, ram_address}, 15'h4A);
    for (int k = 3; k < 6; k++) slot(3'(k), 1'b0, 5'd0);
    reg_enable = 5'b11111;

    // Slot 4, wave_address 3: bank depends on the build
    push(-128 * 15 * 4 + 74 * 15);
    for (int k = 0; k < 4; k++) slot(3'(k), 1'b0, 5'd0);
    slot(3'd4, 1'b1, 5'd3);
`ifdef SCC_SHARED_WAVE_DE_EN
    check("bank_e_addr", {7'd0, ram_address}, 15'h64);
`else
    check("bank_e_addr", {7'd0, ram_address}, 15'h84);
`endif
    slot(3'd5, 1'b0, 5'd0);

`ifdef SCC_SHARED_WAVE_DE_EN
    push(-128 * 15 * 3 + 74 * 15 + 100 * 15);
`else
    push(-128 * 15 * 3 + 74 * 15 - 124 * 15);
`endif
    frame(5'b00000);

    // Mixed volumes: A=1 B=2 C=3 D=0 E=15
    set_vols(4'd1, 4'd2, 4'd3, 4'd0, 4'd15);
`ifdef SCC_SHARED_WAVE_DE_EN
    push(-128 - 256 + 222 + 1500);
`else
    push(-128 - 256 + 222 - 1860);
`endif
    frame(5'b00000);
    set_vols(4'd15, 4'd15, 4'd15, 4'd15, 4'd15);

    // Updates in slots 5, 6, 7 are ignored
    slot(3'd5, 1'b1, 5'd2);
    check("slot5_no_fetch", {14'd0, ram_read}, 15'd0);
    slot(3'd6, 1'b1, 5'd2);
    check("slot6_no_fetch", {14'd0, ram_read}, 15'd0);
    slot(3'd7, 1'b1, 5'd2);
    check("slot7_no_fetch", {14'd0, ram_read}, 15'd0);

    // Reset while a load is in flight
    slot(3'd0, 1'b1, 5'd0);
    check("pre_reset_read", {14'd0, ram_read}, 15'd1);
    reset = 1'b1;
    slot(3'd1, 1'b0, 5'd0);
    check("mid_reset_ram_read", {14'd0, ram_read}, 15'd0);
    check("mid_reset_ram_address", {7'd0, ram_address}, 15'd0);
    check("mid_reset_mix_out", mix_out, 15'd0);
    check("mid_reset_mix_valid", {14'd0, mix_valid}, 15'd0);
    reset = 1'b0;
    push(0);
    frame(5'b00000);

    slot(3'd6, 1'b0, 5'd0);
    slot(3'd6, 1'b0, 5'd0);
    check("queue_empty", 15'(exp_q.size()), 15'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scc_wave_channel_mixer.md
Name: scc_wave_channel_mixer

Overview:
- Consumer end of the tone generator's `wave_address`/`wave_update` interface.
- Works through the same 6-slot `active` time-division sequence. On each update it fetches the next waveform sample from wave RAM and holds one sample per channel.
- Scales each held sample by its channel volume, sums channels A–E, and presents one mixed sample per 6-cycle frame to the audio output stage.

Parameters:
- VOLUME_WIDTH, 4, width of each per-channel volume register.
- Derived, not parameters: product width PW = 8+VOLUME_WIDTH; mix width MW = PW+3 (15 at default).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- active  in  3  slot index; 0..4 = channels A..E, 5 = idle slot; 6, 7 never driven but handled
- wave_address  in  5  current wave pointer of the channel in slot `active`
- wave_update  in  1  pointer of the channel in slot `active` advances at the end of this cycle
- ram_address  out  8  wave RAM read address {bank[2:0], index[4:0]}, registered
- ram_read  out  1  read strobe, registered; RAM returns data exactly 1 cycle later
- ram_rdata  in  8  signed two's-complement sample from wave RAM
- reg_volume_a..reg_volume_e  in  VOLUME_WIDTH each  unsigned channel volume
- reg_enable  in  5  channel enable, bit k = channel k
- mix_out  out  MW  signed mixed sample, registered
- mix_valid  out  1  1-cycle pulse when mix_out updates

Behaviour:
- Reset values: ram_address=0, ram_read=0, mix_out=0, mix_valid=0, samples A..E=0, accumulator=0, pending-load flag=0.
- Fetch when active=k (k<5) and wave_update=1:
  - next cycle: ram_read=1, ram_address={bank(k), wave_address+5'd1}. Index wraps 31→0 (5-bit modulo).
  - record pending channel k.
  - bank(k)=k.
- Fetch in any other case: next cycle ram_read=0 and ram_address holds its previous value.
- Sample load: in the cycle where ram_read=1 (slot k+1), latch ram_rdata into sample[k] at that clock edge. Channel E data lands during slot 5.
- Load latency: 2 cycles from the wave_update cycle to sample[k] valid.
- Only one request is ever in flight. A new request issued in the same cycle a load completes is legal and is tracked independently.
- Accumulate:
  - product_k = signed(sample[k]) × unsigned(volume_k), PW bits signed.
  - product_k is forced to 0 when reg_enable[k]=0. The sample still updates while disabled.
  - slot 0: acc <= sign-extended product_0 (overwrite, no carry-in).
  - slots 1..4: acc <= acc + product_k.
  - Each slot uses the sample value registered at the start of that cycle. A load for channel k issued in the same frame is visible from the next frame.
- Output: slot 5: mix_out <= acc, mix_valid=1 for exactly that cycle. One pulse per 6-cycle frame.
- Width rule: at default widths the worst case is ±1920×5 = −9600..+9525, which fits 15 bits. No saturation and no truncation.
- Slots 6, 7: no fetch, no accumulate, no output, mix_valid=0. A pending load still completes.
- Reset mid-operation: an in-flight load is discarded, all state returns to reset values, and the next frame starts clean at slot 0.
- wave_update during slot 5, 6 or 7 is ignored.

Optional Feature:
- Macro SCC_SHARED_WAVE_DE_EN.
- Defined: original-SCC compatibility. bank(4)=3, so channel E fetches from channel D's waveform bank. RAM bank 4 is never addressed.
- Not defined: five independent banks (SCC+ mode), bank(k)=k.
- Mixing and timing are identical in both builds.

Test Plan:
- Reset then run 3 frames with no updates -> mix_out=0, mix_valid pulses only in slot 5, ram_read never asserted.
- Model RAM with data = low byte of address. Slot 2 with wave_address=7 and update -> next cycle ram_address=0x48, ram_read=1; the cycle after, sample C=0x48.
- Slot 1 with wave_address=31 and update -> ram_address=0x20 (index wraps to 0).
- Load samples A=0x80 (−128) and B..E=0x80, all volumes 15, all enabled -> next frame mix_out=−9600 (0x5A80 in 15 bits), single mix_valid in slot 5.
- Load samples with volumes 15; clear reg_enable[2] -> mix_out drops by exactly product_C; sample C keeps updating.
- Build with SCC_SHARED_WAVE_DE_EN: slot 4 update with wave_address=3 -> ram_address=0x64. Without the macro -> 0x84.
- Assert reset during the cycle where ram_read=1 -> no sample latched, all outputs 0 next cycle.
